// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 correlation engine: FSM encoding,
// operand counts, counter/index types and the pixel address helper.
package conv_pkg;

    localparam int N_IN  = 16;
    localparam int N_F   = 9;
    localparam int N_POS = 4;
    localparam int N_TAP = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [1:0] pos_t;   // output position, p = pos[1], q = pos[0]
    typedef logic [3:0] tap_t;   // filter tap 0..8, also the filter operand index
    typedef logic [3:0] xidx_t;  // input operand index 0..15

    localparam tap_t TAP_LAST = tap_t'(N_TAP - 1);
    localparam pos_t POS_LAST = pos_t'(N_POS - 1);

    // Row-major index of x[p+i][q+j] for the current position and tap.
    function automatic xidx_t x_index(input pos_t pos, input tap_t tap);
        tap_t i;
        tap_t j;
        i = tap / 4'd3;
        j = tap % 4'd3;
        return ((({3'b000, pos[1]} + i) << 2) + {3'b000, pos[0]} + j);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
// `sum` exposes acc + product so the caller can capture a finished dot product.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc;

    assign prod = a * b;
    assign sum  = acc + ACC_W'(prod);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Valid-mode 3x3 correlation over a latched 4x4 matrix, one tap per cycle
// through a single shared MAC; consumer of the operand memory's done/out_* bus.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic [DATA_W-1:0] in_5,
    input  logic [DATA_W-1:0] in_6,
    input  logic [DATA_W-1:0] in_7,
    input  logic [DATA_W-1:0] in_8,
    input  logic [DATA_W-1:0] in_9,
    input  logic [DATA_W-1:0] in_10,
    input  logic [DATA_W-1:0] in_11,
    input  logic [DATA_W-1:0] in_12,
    input  logic [DATA_W-1:0] in_13,
    input  logic [DATA_W-1:0] in_14,
    input  logic [DATA_W-1:0] in_15,
    input  logic [DATA_W-1:0] in_16,
    input  logic [DATA_W-1:0] f_1,
    input  logic [DATA_W-1:0] f_2,
    input  logic [DATA_W-1:0] f_3,
    input  logic [DATA_W-1:0] f_4,
    input  logic [DATA_W-1:0] f_5,
    input  logic [DATA_W-1:0] f_6,
    input  logic [DATA_W-1:0] f_7,
    input  logic [DATA_W-1:0] f_8,
    input  logic [DATA_W-1:0] f_9,
    output logic [ACC_W-1:0]  out_1,
    output logic [ACC_W-1:0]  out_2,
    output logic [ACC_W-1:0]  out_3,
    output logic [ACC_W-1:0]  out_4,
    output logic              busy,
    output logic              done_conv
);

    logic [DATA_W-1:0] in_arr [N_IN];
    logic [DATA_W-1:0] f_arr  [N_F];
    logic [DATA_W-1:0] x_reg  [N_IN];
    logic [DATA_W-1:0] w_reg  [N_F];

    state_e            state;
    pos_t              pos;
    tap_t              tap;
    logic              tap_last;
    logic              mac_clr;
    logic              mac_en;
    logic [ACC_W-1:0]  mac_sum;

    assign in_arr = '{in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8,
                      in_9, in_10, in_11, in_12, in_13, in_14, in_15, in_16};
    assign f_arr  = '{f_1, f_2, f_3, f_4, f_5, f_6, f_7, f_8, f_9};

    // NOTE: operand registers carry no reset; LOAD always overwrites them
    // before MAC reads them, so a reset network there would buy nothing.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            x_reg <= in_arr;
            w_reg <= f_arr;
        end
    end

    assign tap_last = (tap == TAP_LAST);
    assign mac_en   = (state == ST_MAC);
    // The final tap's sum is captured into out_* while the accumulator clears.
    assign mac_clr  = (state == ST_LOAD) || (mac_en && tap_last);
    assign busy     = (state == ST_LOAD) || (state == ST_MAC);

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (x_reg[x_index(pos, tap)]),
        .b   (w_reg[tap]),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pos       <= '0;
            tap       <= '0;
            out_1     <= '0;
            out_2     <= '0;
            out_3     <= '0;
            out_4     <= '0;
            done_conv <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    pos       <= '0;
                    tap       <= '0;
                    out_1     <= '0;
                    out_2     <= '0;
                    out_3     <= '0;
                    out_4     <= '0;
                    done_conv <= 1'b0;
                    state     <= ST_MAC;
                end
                ST_MAC: begin
                    if (tap_last) begin
                        tap <= '0;
                        pos <= pos + 2'd1;
                        case (pos)
                            2'd0:    out_1 <= mac_sum;
                            2'd1:    out_2 <= mac_sum;
                            2'd2:    out_3 <= mac_sum;
                            default: out_4 <= mac_sum;
                        endcase
                        if (pos == POS_LAST) begin
                            done_conv <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                ST_DONE: begin
                    // A held start must never retrigger; it has to fall first.
                    if (!start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: stimulus pushes hand-computed results,
// a monitor pops and compares them on every rising edge of done_conv.
module tb_conv3x3_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int LAT    = 37;

    typedef struct {
        logic [ACC_W-1:0] y0;
        logic [ACC_W-1:0] y1;
        logic [ACC_W-1:0] y2;
        logic [ACC_W-1:0] y3;
        int               n_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [DATA_W-1:0] in_v [16];
    logic [DATA_W-1:0] f_v  [9];
    logic [ACC_W-1:0]  out_1, out_2, out_3, out_4;
    logic              busy, done_conv;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv3x3_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_1(in_v[0]),   .in_2(in_v[1]),   .in_3(in_v[2]),   .in_4(in_v[3]),
        .in_5(in_v[4]),   .in_6(in_v[5]),   .in_7(in_v[6]),   .in_8(in_v[7]),
        .in_9(in_v[8]),   .in_10(in_v[9]),  .in_11(in_v[10]), .in_12(in_v[11]),
        .in_13(in_v[12]), .in_14(in_v[13]), .in_15(in_v[14]), .in_16(in_v[15]),
        .f_1(f_v[0]), .f_2(f_v[1]), .f_3(f_v[2]), .f_4(f_v[3]), .f_5(f_v[4]),
        .f_6(f_v[5]), .f_7(f_v[6]), .f_8(f_v[7]), .f_9(f_v[8]),
        .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
        .busy(busy), .done_conv(done_conv)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input int y0, input int y1, input int y2, input int y3, input int n_edge);
        exp_t e;
        e.y0 = ACC_W'(y0);
        e.y1 = ACC_W'(y1);
        e.y2 = ACC_W'(y2);
        e.y3 = ACC_W'(y3);
        e.n_edge = n_edge;
        sb.push_back(e);
    endtask

    task automatic set_all(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] fv);
        for (int k = 0; k < 16; k++) in_v[k] = xv;
        for (int k = 0; k < 9; k++)  f_v[k]  = fv;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) in_v[k] = DATA_W'(k + 1);
    endtask

    // Raise start at a negedge; returns after the LOAD edge (state MAC).
    task automatic launch(input string name, input int y0, input int y1, input int y2, input int y3);
        push(y0, y1, y2, y3, cyc + 1);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_busy_in_mac"}, 32'(busy), 1);
        check({name, "_done_cleared"}, 32'(done_conv), 0);
        check({name, "_outs_zero_after_load"}, 32'(out_1 | out_2 | out_3 | out_4), 0);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_conv !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, 32'(done_conv), 1);
        check({name, "_busy_low_at_done"}, 32'(busy), 0);
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_conv === 1'b1 && prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_out_1", 32'(out_1), 32'(e.y0));
                    check("sb_out_2", 32'(out_2), 32'(e.y1));
                    check("sb_out_3", 32'(out_3), 32'(e.y2));
                    check("sb_out_4", 32'(out_4), 32'(e.y3));
                    check("sb_latency", 32'(cyc - e.n_edge), LAT);
                end
            end
            prev = done_conv;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic busy_seen;
        set_all(0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_1", 32'(out_1), 0);
        check("reset_out_2", 32'(out_2), 0);
        check("reset_out_3", 32'(out_3), 0);
        check("reset_out_4", 32'(out_4), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done_conv), 0);
        rst = 1'b0;
        @(negedge clk);

        // All ones, start pulsed and dropped early in MAC.
        set_all(1, 1);
        launch("ones", 9, 9, 9, 9);
        start = 1'b0;
        wait_done("ones");
        @(negedge clk);

        // Ramp inputs, unit filter.
        set_ramp();
        for (int k = 0; k < 9; k++) f_v[k] = 1;
        launch("ramp", 54, 63, 90, 99);
        wait_done("ramp");
        start = 1'b0;
        @(negedge clk);

        // Centre-identity filter picks x[1][1], x[1][2], x[2][1], x[2][2].
        in_v = '{8'd17, 8'd203, 8'd5, 8'd88, 8'd142, 8'd61, 8'd230, 8'd9,
                 8'd77, 8'd190, 8'd33, 8'd250, 8'd4, 8'd126, 8'd99, 8'd58};
        for (int k = 0; k < 9; k++) f_v[k] = 0;
        f_v[4] = 1;
        launch("ident", 61, 230, 190, 33);
        wait_done("ident");
        start = 1'b0;
        @(negedge clk);

        // Full-scale operands; ports scrambled mid-MAC must not matter.
        set_all(8'd255, 8'd255);
        launch("max", 585225, 585225, 585225, 585225);
        repeat (5) @(negedge clk);
        set_all(8'd3, 8'd7);
        wait_done("max");
        start = 1'b0;
        @(negedge clk);

        // Reset at MAC cycle 20 with start held; recompute follows on its own.
        set_ramp();
        for (int k = 0; k < 9; k++) f_v[k] = 1;
        start = 1'b1;
        repeat (22) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        push(54, 63, 90, 99, cyc + 2);
        @(negedge clk);
        check("abort_outs_zero", 32'(out_1 | out_2 | out_3 | out_4), 0);
        check("abort_done_zero", 32'(done_conv), 0);
        check("abort_busy_zero", 32'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wait_done("rerun");

        // Start held high after done: no rerun.
        busy_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check("hold_no_busy", 32'(busy_seen), 0);
        check("hold_done_high", 32'(done_conv), 1);

        // New operands after a start drop; corner taps catch a flipped filter.
        start = 1'b0;
        @(negedge clk);
        check("idle_done_held", 32'(done_conv), 1);
        check("idle_out_1_held", 32'(out_1), 54);
        set_ramp();
        for (int k = 0; k < 9; k++) f_v[k] = 0;
        f_v[0] = 2;
        f_v[8] = 3;
        launch("corner", 35, 40, 55, 60);
        repeat (8) @(negedge clk);
        check("corner_out_1_before_write", 32'(out_1), 0);
        @(negedge clk);
        check("corner_out_1_written", 32'(out_1), 35);
        check("corner_out_2_still_zero", 32'(out_2), 0);
        wait_done("corner");
        start = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
